// File: rtl/wb_sdram_bridge_if.sv
// Bus bundle between a Wishbone classic master, the bridge and the SDRAM
// controller's single-entry request port.
interface wb_sdram_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic        ctrl_busy;
  logic [31:0] ctrl_rdata;
  logic        ctrl_out_valid;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
    input  ctrl_busy, ctrl_rdata, ctrl_out_valid
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
    output ctrl_busy, ctrl_rdata, ctrl_out_valid
  );
endinterface

// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave in front of the SDRAM controller: one aligned prefetch
// line for reads, write-through writes, read-modify-write for partial writes.
module wb_sdram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          PF_DEPTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  wb_sdram_bridge_if.slave bus
);
  localparam int IW = $clog2(PF_DEPTH);
  localparam int TW = 23 - IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(PF_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, FILL_ISSUE, FILL_WAIT, RMW_ISSUE, RMW_WAIT, WR_ISSUE
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] tag_r;
  logic [PF_DEPTH-1:0] vld_r;
  logic [31:0]   line_r [PF_DEPTH];
  logic [IW-1:0] iss_ptr_r, target_r;
  logic          acked_r;
  logic [22:0]   wa_r;
  logic [31:0]   dat_r;
  logic [3:0]    sel_r;
  logic [31:0]   wdata_r;
  logic          ack_r;
  logic [31:0]   dat_o_r;
  logic [22:0]   addr_r;
  logic          rw_r;
  logic [31:0]   ctrl_wdata_r;
  logic          in_valid_r;

  logic [22:0]   wa_s;
  logic [TW-1:0] tag_s;
  logic [IW-1:0] idx_s;
  logic          req_s, hit_s, wr_hit_s, can_issue_s;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

  assign wa_s  = bus.wbs_adr_i[24:2];
  assign tag_s = wa_s[22:IW];
  assign idx_s = wa_s[IW-1:0];
  assign req_s = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign hit_s = (tag_s == tag_r) & vld_r[idx_s];
  assign wr_hit_s = (wa_r[22:IW] == tag_r) & vld_r[wa_r[IW-1:0]];
  // Back-to-back pulses are forbidden, so a pulse in the last cycle blocks issue.
  assign can_issue_s = ~bus.ctrl_busy & ~in_valid_r;

  assign bus.wbs_ack_o     = ack_r;
  assign bus.wbs_dat_o     = dat_o_r;
  assign bus.ctrl_addr     = addr_r;
  assign bus.ctrl_rw       = rw_r;
  assign bus.ctrl_wdata    = ctrl_wdata_r;
  assign bus.ctrl_in_valid = in_valid_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s && !ack_r) begin
          if (!bus.wbs_we_i) begin
            if (hit_s) state_s = IDLE;
            else       state_s = FILL_ISSUE;
          end else if (bus.wbs_sel_i == 4'h0) begin
            state_s = IDLE;
          end else if ((bus.wbs_sel_i == 4'hF) || hit_s) begin
            state_s = WR_ISSUE;
          end else begin
            state_s = RMW_ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL_ISSUE: begin
        if (can_issue_s) state_s = FILL_WAIT;
        else             state_s = FILL_ISSUE;
      end
      FILL_WAIT: begin
        if (bus.ctrl_out_valid) begin
          if (iss_ptr_r == LAST_IDX) state_s = IDLE;
          else                       state_s = FILL_ISSUE;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      RMW_ISSUE: begin
        if (can_issue_s) state_s = RMW_WAIT;
        else             state_s = RMW_ISSUE;
      end
      RMW_WAIT: begin
        if (bus.ctrl_out_valid) state_s = WR_ISSUE;
        else                    state_s = RMW_WAIT;
      end
      WR_ISSUE: begin
        if (can_issue_s) state_s = IDLE;
        else             state_s = WR_ISSUE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: line buffer, request capture, controller and Wishbone outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r        <= '0;
      vld_r        <= '0;
      iss_ptr_r    <= '0;
      target_r     <= '0;
      acked_r      <= 1'b0;
      wa_r         <= 23'h0;
      dat_r        <= 32'h0;
      sel_r        <= 4'h0;
      wdata_r      <= 32'h0;
      ack_r        <= 1'b0;
      dat_o_r      <= 32'h0;
      addr_r       <= 23'h0;
      rw_r         <= 1'b0;
      ctrl_wdata_r <= 32'h0;
      in_valid_r   <= 1'b0;
      for (int i = 0; i < PF_DEPTH; i++) line_r[i] <= 32'h0;
    end else begin
      ack_r      <= 1'b0;
      in_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s && !ack_r) begin
            wa_r  <= wa_s;
            dat_r <= bus.wbs_dat_i;
            sel_r <= bus.wbs_sel_i;
            if (!bus.wbs_we_i) begin
              if (hit_s) begin
                dat_o_r <= line_r[idx_s];
                ack_r   <= 1'b1;
              end else begin
                tag_r     <= tag_s;
                vld_r     <= '0;
                iss_ptr_r <= '0;
                target_r  <= idx_s;
                acked_r   <= 1'b0;
              end
            end else if (bus.wbs_sel_i == 4'h0) begin
              ack_r <= 1'b1;
            end else if (bus.wbs_sel_i == 4'hF) begin
              wdata_r <= bus.wbs_dat_i;
            end else if (hit_s) begin
              wdata_r <= merge_word(line_r[idx_s], bus.wbs_dat_i, bus.wbs_sel_i);
            end
          end
        end
        FILL_ISSUE: begin
          if (can_issue_s) begin
            in_valid_r <= 1'b1;
            rw_r       <= 1'b0;
            addr_r     <= {tag_r, iss_ptr_r};
          end
        end
        FILL_WAIT: begin
          if (bus.ctrl_out_valid) begin
            line_r[iss_ptr_r] <= bus.ctrl_rdata;
            vld_r[iss_ptr_r]  <= 1'b1;
            // Early ack: the requester gets its word before the line completes.
            if ((iss_ptr_r == target_r) && !acked_r) begin
              dat_o_r <= bus.ctrl_rdata;
              ack_r   <= 1'b1;
              acked_r <= 1'b1;
            end
            if (iss_ptr_r != LAST_IDX) iss_ptr_r <= iss_ptr_r + 1'b1;
          end
        end
        RMW_ISSUE: begin
          if (can_issue_s) begin
            in_valid_r <= 1'b1;
            rw_r       <= 1'b0;
            addr_r     <= wa_r;
          end
        end
        RMW_WAIT: begin
          if (bus.ctrl_out_valid) wdata_r <= merge_word(bus.ctrl_rdata, dat_r, sel_r);
        end
        WR_ISSUE: begin
          if (can_issue_s) begin
            in_valid_r   <= 1'b1;
            rw_r         <= 1'b1;
            addr_r       <= wa_r;
            ctrl_wdata_r <= wdata_r;
            ack_r        <= 1'b1;
            if (wr_hit_s) line_r[wa_r[IW-1:0]] <= wdata_r;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/wb_sdram_bridge.md
Name: wb_sdram_bridge

Overview:
- Wishbone classic slave that sits directly upstream of the SDRAM controller and drives its single-entry user request interface (addr/rw/data/in_valid/busy, data_out/out_valid).
- Holds a PF_DEPTH-word aligned prefetch line: read misses fill the whole line, and later reads hit locally.
- Writes are write-through. Sub-word writes become read-modify-write, because the controller has no byte mask.

Parameters:
- BASE_ADDR, 32'h3800_0000: decode base; only wbs_adr_i[31:24] is compared.
- PF_DEPTH, 8: prefetch line length in 32-bit words; power of two, 2..16. IW = log2(PF_DEPTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data
- ctrl_addr  out  23  word address to controller
- ctrl_rw  out  1  1 = write, 0 = read
- ctrl_wdata  out  32  write data to controller
- ctrl_in_valid  out  1  request pulse
- ctrl_busy  in  1  controller queue full
- ctrl_rdata  in  32  controller read data
- ctrl_out_valid  in  1  read data valid pulse

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, line valid bits all 0, tag 0. The controller must be held in reset over the same interval, or any read in flight is lost and its out_valid is ignored.
- Decode: req = cyc & stb & (adr[31:24] == BASE_ADDR[31:24]). Undecoded requests are never acked.
- Address split: wa = adr[24:2]; tag = wa[22:IW]; idx = wa[IW-1:0].
- Issue rule: ctrl_in_valid is registered and high for exactly one cycle. It may only be raised when ctrl_busy is 0 and ctrl_in_valid was 0 in the previous cycle. The issue cycle is the accept cycle. At most one read is outstanding.
- Ack: wbs_ack_o is a registered one-cycle pulse. IDLE ignores req in the cycle wbs_ack_o is high, so the same request is not re-sampled.
- IDLE:
  - Read hit (tag match and vld[idx]): wbs_dat_o <= buf[idx]; ack in the next cycle. Latency is 1 cycle after req is sampled.
  - Read miss: tag <= new tag; vld <= 0; iss_ptr <= 0; target <= idx; acked <= 0; go FILL_ISSUE.
  - Write with sel == 4'hF: wdata <= dat_i; go WR_ISSUE.
  - Partial write, hit: wdata <= merge(buf[idx], dat_i, sel); go WR_ISSUE.
  - Partial write, miss: go RMW_ISSUE.
- FILL_ISSUE: issue a read at {tag, iss_ptr}; go FILL_WAIT.
- FILL_WAIT: on ctrl_out_valid:
  - buf[iss_ptr] <= rdata; vld[iss_ptr] <= 1.
  - If iss_ptr == target: wbs_dat_o <= rdata, ack (early ack), acked <= 1.
  - If iss_ptr == PF_DEPTH-1, go IDLE; else iss_ptr++ and go FILL_ISSUE.
  - New Wishbone requests stall (no ack) until the fill completes.
- RMW_ISSUE / RMW_WAIT: single read at wa; on out_valid, wdata <= merge(rdata, dat_i, sel); go WR_ISSUE. The line is not filled.
- WR_ISSUE: issue a write of wdata at wa; on the issue cycle, ack (posted write).
  - If tag matches and vld[idx], buf[idx] <= wdata, so the line stays coherent.
  - Go IDLE.
- Merge: byte k comes from dat_i when sel[k] is set, else from the old word.
- sel == 0 write: acked, nothing issued, buffer unchanged.
- Ordering: the controller serves requests in order, so a read issued after a posted write returns the new data.
- Index wrap: the fill always covers idx 0..PF_DEPTH-1 of the aligned line, regardless of target.

Test Plan:
- Cold read at 0x3800_0014 (wa=5, PF_DEPTH=8) -> controller sees reads at 0..7 in order, each issued only after the prior out_valid. Ack arrives with word 5 while words 6,7 are still fetching. A second request is not acked until word 7 returns.
- After that fill, read 0x3800_0008 -> ack exactly 1 cycle after req with buf[2]; no ctrl_in_valid.
- Write 0xDEAD_BEEF, sel=4'hF to 0x3800_0008 (hit) -> one write, ack on the issue cycle. A following read of the same address is a hit returning 0xDEAD_BEEF.
- Partial write sel=4'b0010, data 0x0000_AB00 to an uncached word holding 0x1122_3344 -> one read then a write of 0x1122_AB44; ack on the write issue.
- ctrl_busy held high 20 cycles during a write -> ctrl_in_valid stays 0 until busy drops, then pulses once. Request to 0x3000_0000 -> never acked, no controller traffic.
- rst_n low mid-fill at word 3 -> all outputs 0 immediately (async). After release, the old line reads as a miss and a fresh fill starts.
